// File: rtl/lsu_pkg.sv
//==============================================================================
// lsu_pkg -- shared types and constants for the LSU issue arbiter slice
// Revision: 1.0
//==============================================================================
`default_nettype none

package lsu_pkg;

   localparam int XLEN      = 32;
   localparam int ROB_IDX_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_arb_state_t;

   typedef struct packed {
      logic                 wr_rd;
      logic [XLEN-1:0]      addr;
      logic [XLEN-1:0]      data;
      logic [ROB_IDX_W-1:0] rob_idx;
   } lsu_req_t;

   // Counter width able to hold 0..limit; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_starve_counter.sv
//==============================================================================
// lsu_starve_counter -- saturating load-starvation counter
// Revision: 1.0
//==============================================================================
`default_nettype none

module lsu_starve_counter
   import lsu_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_starved
);

   localparam int                 c_cnt_w = cnt_width(LIMIT);
   localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);

   logic [c_cnt_w-1:0] r_cnt;

   // Clear wins over increment; the count parks at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt < c_limit)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_starved = (r_cnt >= c_limit);

endmodule

`default_nettype wire

// File: rtl/lsu_issue_arbiter.sv
//==============================================================================
// lsu_issue_arbiter -- picks LDQ or SDQ head and presents it to the cache
// Optional: LSU_ARB_STARVE_EN lets a starved load beat a waiting store.
// Revision: 1.0
//==============================================================================
`default_nettype none

module lsu_issue_arbiter
   import lsu_pkg::*;
#(
   parameter int XLEN         = lsu_pkg::XLEN,
   parameter int ROB_IDX_W    = lsu_pkg::ROB_IDX_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 ld_vld_i,
   input  logic [XLEN-1:0]      ld_addr_i,
   input  logic [ROB_IDX_W-1:0] ld_rob_idx_i,
   output logic                 ld_en_o,
   input  logic                 st_vld_i,
   input  logic [XLEN-1:0]      st_addr_i,
   input  logic [XLEN-1:0]      st_data_i,
   output logic                 st_en_o,
   output logic                 req_vld_o,
   output logic                 req_wr_rd_o,
   output logic [XLEN-1:0]      req_addr_o,
   output logic [XLEN-1:0]      req_data_o,
   output logic [ROB_IDX_W-1:0] req_rob_idx_o,
   input  logic                 req_rdy_i,
   input  logic                 ld_done_i,
   output logic                 busy_o
);

   lsu_arb_state_t r_state, w_state_nxt;
   lsu_req_t       r_req, w_req_nxt;
   logic           w_ld_grant;
   logic           w_st_grant;
   logic           w_starved;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_req   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_ld_grant  = 1'b0;
      w_st_grant  = 1'b0;
      case (r_state)
         IDLE: begin
            // A flush squashes the load candidate but never a committed store.
            if (ld_vld_i && !flush_i && (!st_vld_i || w_starved)) begin
               w_ld_grant  = 1'b1;
               w_req_nxt   = '{wr_rd: 1'b0, addr: ld_addr_i, data: '0,
                               rob_idx: ld_rob_idx_i};
               w_state_nxt = REQ;
            end else if (st_vld_i) begin
               w_st_grant  = 1'b1;
               w_req_nxt   = '{wr_rd: 1'b1, addr: st_addr_i, data: st_data_i,
                               rob_idx: '0};
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (flush_i && !r_req.wr_rd) begin
               w_state_nxt = IDLE;
            end else if (req_rdy_i) begin
               w_state_nxt = r_req.wr_rd ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (ld_done_i) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef LSU_ARB_STARVE_EN
   logic w_starve_inc;
   logic w_starve_clr;

   assign w_starve_inc = (r_state == IDLE) && ld_vld_i && !w_ld_grant;
   assign w_starve_clr = w_ld_grant || flush_i;

   lsu_starve_counter #(
      .LIMIT     (STARVE_LIMIT)
   ) u_starve (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .i_inc     (w_starve_inc),
      .i_clr     (w_starve_clr),
      .o_starved (w_starved)
   );
`else
   logic w_unused_starve_limit;

   assign w_starved             = 1'b0;
   assign w_unused_starve_limit = (STARVE_LIMIT != 0);
`endif

   // The state is forced to IDLE by reset, so the grants need explicit gating.
   assign ld_en_o       = w_ld_grant & rst_i;
   assign st_en_o       = w_st_grant & rst_i;
   assign req_vld_o     = (r_state == REQ);
   assign busy_o        = (r_state != IDLE);
   assign req_wr_rd_o   = r_req.wr_rd;
   assign req_addr_o    = r_req.addr;
   assign req_data_o    = r_req.data;
   assign req_rob_idx_o = r_req.rob_idx;

endmodule

`default_nettype wire

// File: tb/tb_lsu_issue_arbiter.sv
//==============================================================================
// tb_lsu_issue_arbiter -- directed self-checking bench for lsu_issue_arbiter
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_lsu_issue_arbiter;

   localparam int XLEN = 32;
   localparam int RW   = 5;
`ifdef LSU_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_i;
   logic            flush_i;
   logic            ld_vld_i;
   logic [XLEN-1:0] ld_addr_i;
   logic [RW-1:0]   ld_rob_idx_i;
   logic            ld_en_o;
   logic            st_vld_i;
   logic [XLEN-1:0] st_addr_i;
   logic [XLEN-1:0] st_data_i;
   logic            st_en_o;
   logic            req_vld_o;
   logic            req_wr_rd_o;
   logic [XLEN-1:0] req_addr_o;
   logic [XLEN-1:0] req_data_o;
   logic [RW-1:0]   req_rob_idx_o;
   logic            req_rdy_i;
   logic            ld_done_i;
   logic            busy_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lsu_issue_arbiter #(
      .XLEN          (XLEN),
      .ROB_IDX_W     (RW),
      .STARVE_LIMIT  (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .ld_vld_i      (ld_vld_i),
      .ld_addr_i     (ld_addr_i),
      .ld_rob_idx_i  (ld_rob_idx_i),
      .ld_en_o       (ld_en_o),
      .st_vld_i      (st_vld_i),
      .st_addr_i     (st_addr_i),
      .st_data_i     (st_data_i),
      .st_en_o       (st_en_o),
      .req_vld_o     (req_vld_o),
      .req_wr_rd_o   (req_wr_rd_o),
      .req_addr_o    (req_addr_o),
      .req_data_o    (req_data_o),
      .req_rob_idx_o (req_rob_idx_o),
      .req_rdy_i     (req_rdy_i),
      .ld_done_i     (ld_done_i),
      .busy_o        (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b0; flush_i = 1'b0; ld_vld_i = 1'b0; ld_addr_i = '0; ld_rob_idx_i = '0;
      st_vld_i = 1'b0; st_addr_i = '0; st_data_i = '0; req_rdy_i = 1'b0; ld_done_i = 1'b0;

      // Reset state, with a valid load head that must not be popped.
      cyc(); ld_vld_i = 1'b1; settle();
      chk("rst_ld_en", ld_en_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_req_vld", req_vld_o, 0);
      chk("rst_addr", req_addr_o, 0);
      cyc(); ld_vld_i = 1'b0; rst_i = 1'b1;

      // Single load through REQ and WAIT.
      cyc(); ld_vld_i = 1'b1; ld_addr_i = 32'h100; ld_rob_idx_i = 5'd3; settle();
      chk("ld1_en", ld_en_o, 1);
      chk("ld1_st_en", st_en_o, 0);
      cyc(); ld_vld_i = 1'b0; settle();
      chk("ld1_vld", req_vld_o, 1);
      chk("ld1_wr_rd", req_wr_rd_o, 0);
      chk("ld1_addr", req_addr_o, 32'h100);
      chk("ld1_rob", req_rob_idx_o, 3);
      chk("ld1_data", req_data_o, 0);
      req_rdy_i = 1'b1;
      cyc(); req_rdy_i = 1'b0; flush_i = 1'b1; ld_vld_i = 1'b1; settle();
      chk("ld1_wait_vld", req_vld_o, 0);
      chk("ld1_wait_busy", busy_o, 1);
      chk("ld1_wait_no_grant", ld_en_o, 0);
      cyc(); flush_i = 1'b0; ld_done_i = 1'b1; settle();
      chk("ld1_wait_flush_ign", busy_o, 1);
      chk("ld1_done_no_grant", ld_en_o, 0);
      cyc(); ld_done_i = 1'b0; ld_vld_i = 1'b0; settle();
      chk("ld1_idle", busy_o, 0);

      // Simultaneous load and store: store first, load in the next IDLE cycle.
      ld_vld_i = 1'b1; ld_addr_i = 32'h104; ld_rob_idx_i = 5'd7;
      st_vld_i = 1'b1; st_addr_i = 32'h200; st_data_i = 32'hDEADBEEF; settle();
      chk("both_st_en", st_en_o, 1);
      chk("both_ld_en", ld_en_o, 0);
      cyc(); st_vld_i = 1'b0; req_rdy_i = 1'b1; settle();
      chk("st_wr_rd", req_wr_rd_o, 1);
      chk("st_addr", req_addr_o, 32'h200);
      chk("st_data", req_data_o, 32'hDEADBEEF);
      chk("st_req_no_ld", ld_en_o, 0);
      cyc(); req_rdy_i = 1'b0; settle();
      chk("st_posted_idle", busy_o, 0);
      chk("ld2_en", ld_en_o, 1);
      cyc(); ld_vld_i = 1'b0; st_vld_i = 1'b1; st_addr_i = 32'h204; settle();
      chk("ld2_addr", req_addr_o, 32'h104);
      chk("ld2_data", req_data_o, 0);

      // Backpressure on the load for five cycles.
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("bp_vld", req_vld_o, 1);
         chk("bp_addr", req_addr_o, 32'h104);
         chk("bp_rob", req_rob_idx_o, 7);
         chk("bp_wr_rd", req_wr_rd_o, 0);
         chk("bp_busy", busy_o, 1);
         chk("bp_en", {ld_en_o, st_en_o}, 0);
         cyc();
      end

      // Flush beats a same-cycle accept for a load.
      st_vld_i = 1'b0; flush_i = 1'b1; req_rdy_i = 1'b1;
      cyc(); flush_i = 1'b0; req_rdy_i = 1'b0; settle();
      chk("fl_ld_vld", req_vld_o, 0);
      chk("fl_ld_busy", busy_o, 0);

      // Flush while holding a store is ignored.
      st_vld_i = 1'b1; st_addr_i = 32'h300; st_data_i = 32'h12345678; settle();
      chk("fl_st_en", st_en_o, 1);
      cyc(); st_vld_i = 1'b0; flush_i = 1'b1;
      cyc(); flush_i = 1'b0; settle();
      chk("fl_st_vld", req_vld_o, 1);
      chk("fl_st_addr", req_addr_o, 32'h300);
      chk("fl_st_data", req_data_o, 32'h12345678);
      req_rdy_i = 1'b1;
      cyc(); req_rdy_i = 1'b0; settle();
      chk("fl_st_done", busy_o, 0);

      // Flush in IDLE suppresses a load grant.
      flush_i = 1'b1; ld_vld_i = 1'b1; settle();
      chk("fl_idle_ld_en", ld_en_o, 0);
      cyc(); flush_i = 1'b0; ld_vld_i = 1'b0; settle();
      chk("fl_idle_busy", busy_o, 0);

      // Starvation: stores and a load valid every cycle, all accepted at once.
      ld_vld_i = 1'b1; ld_addr_i = 32'h500; ld_rob_idx_i = 5'd12;
      st_vld_i = 1'b1; st_addr_i = 32'h600; st_data_i = 32'hA5A5A5A5; req_rdy_i = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         settle();
         chk("stv_ld_en", ld_en_o, (STARVE && k == 5) ? 1 : 0);
         chk("stv_st_en", st_en_o, (STARVE && k == 5) ? 0 : 1);
         cyc(); settle();
         chk("stv_wr_rd", req_wr_rd_o, (STARVE && k == 5) ? 0 : 1);
         cyc();
      end
      ld_vld_i = 1'b0; st_vld_i = 1'b0; req_rdy_i = 1'b0;
      if (STARVE) begin
         ld_done_i = 1'b1;
         cyc(); ld_done_i = 1'b0;
      end
      settle();
      chk("stv_end_idle", busy_o, 0);

      // Reset asserted mid-WAIT, then a stale ld_done_i.
      cyc(); ld_vld_i = 1'b1; ld_addr_i = 32'h400; ld_rob_idx_i = 5'd9; settle();
      chk("rw_ld_en", ld_en_o, 1);
      cyc(); ld_vld_i = 1'b0; req_rdy_i = 1'b1;
      cyc(); req_rdy_i = 1'b0; ld_vld_i = 1'b1; settle();
      chk("rw_in_wait", busy_o, 1);
      #2 rst_i = 1'b0; settle();
      chk("rw_busy", busy_o, 0);
      chk("rw_req_vld", req_vld_o, 0);
      chk("rw_ld_en0", ld_en_o, 0);
      chk("rw_st_en0", st_en_o, 0);
      chk("rw_addr0", req_addr_o, 0);
      chk("rw_rob0", req_rob_idx_o, 0);
      cyc(); ld_vld_i = 1'b0;
      cyc(); rst_i = 1'b1;
      cyc(); ld_done_i = 1'b1;
      cyc(); ld_done_i = 1'b0; settle();
      chk("rw_late_done_busy", busy_o, 0);
      chk("rw_late_done_vld", req_vld_o, 0);
      st_vld_i = 1'b1; st_addr_i = 32'h700; settle();
      chk("rw_post_st_en", st_en_o, 1);
      cyc(); st_vld_i = 1'b0; settle();
      chk("rw_post_addr", req_addr_o, 32'h700);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
